// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: source indices,
// destination-mux select codes and the fixed register address width.
package rf_wb_arbiter_pkg;

  localparam int ADDR_W = 4;
  localparam int NSRC   = 3;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;

  localparam logic [1:0] WB_SEL_A = 2'b00;
  localparam logic [1:0] WB_SEL_B = 2'b01;
  localparam logic [1:0] WB_SEL_C = 2'b11;

  // The mux decodes 10 as nothing, so every index must land on a legal code.
  function automatic logic [1:0] sel_code(input logic [1:0] src);
    case (src)
      SRC_A:   sel_code = WB_SEL_A;
      SRC_B:   sel_code = WB_SEL_B;
      default: sel_code = WB_SEL_C;
    endcase
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/response bundle between the execute/memory stages,
// the arbiter and the register-file write port.
interface rf_wb_arbiter_if #(parameter int DATA_W = 32);
  import rf_wb_arbiter_pkg::*;

  logic              a_valid, b_valid, c_valid;
  logic              a_ready, b_ready, c_ready;
  logic [ADDR_W-1:0] a_addr,  b_addr,  c_addr;
  logic [DATA_W-1:0] a_data,  b_data,  c_data;
  logic              wb_hold;
  logic [ADDR_W-1:0] mux_in_a, mux_in_b, mux_in_c;
  logic [1:0]        wb_sel;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;

  modport slave (
    input  a_valid, b_valid, c_valid, a_addr, b_addr, c_addr,
           a_data, b_data, c_data, wb_hold,
    output a_ready, b_ready, c_ready, mux_in_a, mux_in_b, mux_in_c,
           wb_sel, rf_we, rf_wd
  );

  modport master (
    output a_valid, b_valid, c_valid, a_addr, b_addr, c_addr,
           a_data, b_data, c_data, wb_hold,
    input  a_ready, b_ready, c_ready, mux_in_a, mux_in_b, mux_in_c,
           wb_sel, rf_we, rf_wd
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb3.sv
// Combinational 3-way round-robin picker: first pending source after the
// last grant, in A -> B -> C -> A order.
module rr_arb3
  import rf_wb_arbiter_pkg::*;
(
  input  logic [NSRC-1:0] i_pending,
  input  logic [1:0]      i_last,
  output logic [NSRC-1:0] o_grant,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    case (i_last)
      SRC_A: begin
        if      (i_pending[SRC_B]) o_grant[SRC_B] = 1'b1;
        else if (i_pending[SRC_C]) o_grant[SRC_C] = 1'b1;
        else if (i_pending[SRC_A]) o_grant[SRC_A] = 1'b1;
      end
      SRC_B: begin
        if      (i_pending[SRC_C]) o_grant[SRC_C] = 1'b1;
        else if (i_pending[SRC_A]) o_grant[SRC_A] = 1'b1;
        else if (i_pending[SRC_B]) o_grant[SRC_B] = 1'b1;
      end
      default: begin
        if      (i_pending[SRC_A]) o_grant[SRC_A] = 1'b1;
        else if (i_pending[SRC_B]) o_grant[SRC_B] = 1'b1;
        else if (i_pending[SRC_C]) o_grant[SRC_C] = 1'b1;
      end
    endcase
  end

  assign o_any = |i_pending;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one-deep buffer per source, round-robin
// issue onto the single RF write port with registered we/sel/data.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  rf_wb_arbiter_if.slave bus
);

  logic [NSRC-1:0]             w_valid, w_acc, w_grant;
  logic [NSRC-1:0][ADDR_W-1:0] w_addr_in;
  logic [NSRC-1:0][DATA_W-1:0] w_data_in;
  logic                        w_any, w_issue;
  logic [1:0]                  w_win;

  logic [NSRC-1:0]             r_pend;
  logic [NSRC-1:0][ADDR_W-1:0] r_addr;
  logic [NSRC-1:0][DATA_W-1:0] r_data;
  logic [1:0]                  r_last, r_sel;
  logic                        r_we;
  logic [DATA_W-1:0]           r_wd;

  assign w_valid   = {bus.c_valid, bus.b_valid, bus.a_valid};
  assign w_addr_in = {bus.c_addr,  bus.b_addr,  bus.a_addr};
  assign w_data_in = {bus.c_data,  bus.b_data,  bus.a_data};

  assign w_acc   = w_valid & ~r_pend;
  assign w_issue = w_any & ~bus.wb_hold;
  assign w_win   = w_grant[SRC_C] ? SRC_C : (w_grant[SRC_B] ? SRC_B : SRC_A);

  rr_arb3 u_arb (
    .i_pending (r_pend),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_any     (w_any)
  );

  // A source cannot be accepted and issued at the same edge: accept needs
  // an empty buffer, issue needs a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_last <= SRC_C;
      r_sel  <= WB_SEL_A;
      r_we   <= 1'b0;
      r_wd   <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (w_acc[i]) begin
          r_pend[i] <= 1'b1;
          r_addr[i] <= w_addr_in[i];
          r_data[i] <= w_data_in[i];
        end else if (w_issue && w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      r_we <= w_issue;
      if (w_issue) begin
        r_sel  <= sel_code(w_win);
        r_wd   <= r_data[w_win];
        r_last <= w_win;
      end
    end
  end

  assign bus.a_ready  = ~r_pend[SRC_A];
  assign bus.b_ready  = ~r_pend[SRC_B];
  assign bus.c_ready  = ~r_pend[SRC_C];
  assign bus.mux_in_a = r_addr[SRC_A];
  assign bus.mux_in_b = r_addr[SRC_B];
  assign bus.mux_in_c = r_addr[SRC_C];
  assign bus.wb_sel   = r_sel;
  assign bus.rf_we    = r_we;
  assign bus.rf_wd    = r_wd;

endmodule
